gsim_mem_responder: RTL and testbench

- Read-side responder for the GSIM matrix-memory interface. It serves the solver's 256-bit line requests from a 64-bit single-port SRAM macro.
- On each accepted request it fetches BEATS consecutive 64-bit words, assembles them into one line and returns it with a one-cycle valid pulse.
- A single-entry line buffer answers repeated reads of the same line with a 1-cycle response.

---
 rtl/gsim_mem_responder.sv | 132 +++++++++++++
 tb/tb_gsim_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gsim_mem_responder.sv
// Read-side line responder: assembles BEATS SRAM words into one line and
// answers repeated reads of the most recent line from a single-entry buffer.
module gsim_mem_responder #(
  parameter int AW       = 10,
  parameter int BEATS    = 4,
  parameter int SRAM_DW  = 64,
  parameter int SRAM_AW  = 12,
  parameter int SRAM_LAT = 1,
  localparam int LW      = BEATS * SRAM_DW,
  localparam int KW      = $clog2(BEATS)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_mem_rreq,
  input  logic [AW-1:0]      i_mem_addr,
  output logic               o_mem_rrdy,
  output logic [LW-1:0]      o_mem_dout,
  output logic               o_mem_dout_vld,
  input  logic               i_inv,
  output logic               o_sram_ren,
  output logic [SRAM_AW-1:0] o_sram_addr,
  input  logic [SRAM_DW-1:0] i_sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RESP} state_e;

  state_e                   state_q;
  logic                     ren_q;
  logic [SRAM_AW-1:0]       sram_addr_q;
  logic [LW-1:0]            dout_q;
  logic                     dout_vld_q;
  logic [LW-1:0]            line_q, line_d;
  logic [AW-1:0]            tag_q;
  logic                     tag_vld_q;
  logic                     inv_seen_q;
  logic [SRAM_LAT-1:0]      cap_vld_q;
  logic [SRAM_LAT*KW-1:0]   cap_beat_q;

  logic          accept, hit, cap_vld, last_cap, last_issue;
  logic [KW-1:0] cap_beat;

  assign o_mem_rrdy     = (state_q == S_IDLE) || (state_q == S_RESP);
  assign o_mem_dout     = dout_q;
  assign o_mem_dout_vld = dout_vld_q;
  assign o_sram_ren     = ren_q;
  assign o_sram_addr    = sram_addr_q;

  assign accept     = i_mem_rreq && o_mem_rrdy;
  assign hit        = tag_vld_q && (tag_q == i_mem_addr) && !i_inv;
  assign last_issue = (sram_addr_q[KW-1:0] == KW'(BEATS - 1));
  // Beat index travels with each issued read so the data lands in the right slot.
  assign cap_vld    = cap_vld_q[SRAM_LAT-1];
  assign cap_beat   = cap_beat_q[SRAM_LAT*KW-1 -: KW];
  assign last_cap   = cap_vld && (cap_beat == KW'(BEATS - 1));

  always_comb begin
    // NOTE: default assignment first so every path drives line_d; without it
    // the partial slot update below would infer a latch.
    line_d = line_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cap_vld && (cap_beat == KW'(k))) line_d[k*SRAM_DW +: SRAM_DW] = i_sram_rdata;
    end
  end

  // NOTE: the line storage is data-only and is guarded by tag_vld_q, so it is
  // deliberately left out of the reset domain.
  always_ff @(posedge i_clk) begin
    line_q <= line_d;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      ren_q       <= 1'b0;
      sram_addr_q <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      tag_q       <= '0;
      tag_vld_q   <= 1'b0;
      inv_seen_q  <= 1'b0;
      cap_vld_q   <= '0;
      cap_beat_q  <= '0;
    end else begin
      dout_vld_q <= 1'b0;
      cap_vld_q  <= SRAM_LAT'({cap_vld_q, ren_q});
      cap_beat_q <= (SRAM_LAT*KW)'({cap_beat_q, sram_addr_q[KW-1:0]});
      if (i_inv) tag_vld_q <= 1'b0;

      unique case (state_q)
        S_IDLE, S_RESP: begin
          if (accept && hit) begin
            state_q    <= S_RESP;
            dout_vld_q <= 1'b1;
            dout_q     <= line_q;
          end else if (accept) begin
            state_q     <= S_READ;
            ren_q       <= 1'b1;
            sram_addr_q <= {i_mem_addr, KW'(0)};
            tag_vld_q   <= 1'b0;
            inv_seen_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          if (i_inv) inv_seen_q <= 1'b1;
          if (last_issue) begin
            ren_q   <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            sram_addr_q <= sram_addr_q + SRAM_AW'(1);
          end
        end
        S_DRAIN: begin
          if (i_inv) inv_seen_q <= 1'b1;
          if (last_cap) begin
            state_q    <= S_RESP;
            dout_vld_q <= 1'b1;
            dout_q     <= line_d;
            tag_q      <= sram_addr_q[SRAM_AW-1:KW];
            // An invalidate seen anywhere during the fill keeps the tag out.
            tag_vld_q  <= !(inv_seen_q || i_inv);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_mem_responder.sv
// Scoreboard bench for gsim_mem_responder: stimulus pushes expected responses
// and SRAM reads; a negedge monitor pops and compares them.
module tb_gsim_mem_responder;

  localparam int AW  = 10;
  localparam int SAW = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rreq = 1'b0;
  logic           inv = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic           rrdy;
  logic [255:0]   dout;
  logic           vld;
  logic           ren;
  logic [SAW-1:0] saddr;
  logic [63:0]    rdata = '0;

  logic [63:0] mem [4096];
  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;

  typedef struct { logic [255:0] line; int cyc; } vexp_t;
  typedef struct { logic [SAW-1:0] a; int cyc; } rexp_t;
  vexp_t vq[$];
  rexp_t rq[$];

  gsim_mem_responder dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_mem_rreq     (rreq),
    .i_mem_addr     (addr),
    .o_mem_rrdy     (rrdy),
    .o_mem_dout     (dout),
    .o_mem_dout_vld (vld),
    .i_inv          (inv),
    .o_sram_ren     (ren),
    .o_sram_addr    (saddr),
    .i_sram_rdata   (rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ren) rdata <= mem[saddr];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [255:0] exp_line(input int a);
    return {mem[4*a+3], mem[4*a+2], mem[4*a+1], mem[4*a]};
  endfunction

  // Monitor: pops one expectation per observed response / SRAM read.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld) begin
        if (vq.size() == 0) check("vld_unexpected", 256'(vld), 256'(0));
        else begin
          vexp_t e;
          e = vq.pop_front();
          check("dout", dout, e.line);
          check("vld_cycle", 256'(cyc), 256'(e.cyc));
        end
      end
      if (ren) begin
        if (rq.size() == 0) check("ren_unexpected", 256'(ren), 256'(0));
        else begin
          rexp_t r;
          r = rq.pop_front();
          check("sram_addr", 256'(saddr), 256'(r.a));
          check("ren_cycle", 256'(cyc), 256'(r.cyc));
        end
      end
    end
  end

  task automatic do_req(input logic [AW-1:0] a, input bit hit, input logic [255:0] line,
                        input bit with_inv, output int acc);
    bit done;
    done = 0;
    acc = -1;
    @(posedge clk); #1;
    rreq = 1'b1;
    addr = a;
    inv  = with_inv;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (rrdy) begin
        done = 1;
        acc  = cyc;
        vq.push_back('{line, cyc + (hit ? 1 : 6)});
        if (!hit) for (int k = 0; k < 4; k++) rq.push_back('{{a, 2'(k)}, cyc + 1 + k});
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("req_accept", 256'(rrdy), 256'(1));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    rreq = 1'b0;
    inv  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100 && (vq.size() != 0 || rq.size() != 0); t++) @(negedge clk);
    check("drain_vq", 256'(vq.size()), 256'(0));
    @(negedge clk);
  endtask

  localparam logic [255:0] LINE3 = {64'd15, 64'd14, 64'd13, 64'd12};
  localparam logic [255:0] LINE3_DEAD = {64'd15, 64'd14, 64'd13, 64'hDEAD};

  initial begin
    int acc, prev;
    for (int n = 0; n < 4096; n++) mem[n] = 64'(n);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rrdy", 256'(rrdy), 256'(1));
    check("rst_vld", 256'(vld), 256'(0));
    check("rst_dout", dout, 256'(0));
    check("rst_ren", 256'(ren), 256'(0));
    check("rst_saddr", 256'(saddr), 256'(0));
    rst = 1'b0;

    // Miss on line 3: rrdy low for five cycles after the accept
    do_req(10'd3, 1'b0, LINE3, 1'b0, acc);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      rreq = 1'b0;
      @(negedge clk);
      check("miss_rrdy_low", 256'(rrdy), 256'(0));
    end

    // Hit streak, first one accepted in the response cycle
    for (int i = 0; i < 8; i++) do_req(10'd3, 1'b1, LINE3, 1'b0, acc);
    idle();
    wait_drain();

    // Solver-style sweep with rreq held high: every new miss is accepted in S_RESP
    prev = 0;
    for (int i = 0; i < 17; i++) begin
      int a;
      a = (i == 0) ? 0 : 16 + i;
      do_req(AW'(a), 1'b0, exp_line(a), 1'b0, acc);
      if (i >= 1) check("resp_accept_cycle", 256'(acc), 256'(prev + 6));
      prev = acc;
    end
    idle();
    wait_drain();

    // Invalidate after changing SRAM contents
    do_req(10'd3, 1'b0, LINE3, 1'b0, acc);
    idle();
    wait_drain();
    mem[12] = 64'hDEAD;
    @(posedge clk); #1 inv = 1'b1;
    @(posedge clk); #1 inv = 1'b0;
    do_req(10'd3, 1'b0, LINE3_DEAD, 1'b0, acc);
    idle();
    wait_drain();
    do_req(10'd3, 1'b1, LINE3_DEAD, 1'b0, acc);
    idle();
    wait_drain();
    // Hit request with simultaneous invalidate is a miss
    do_req(10'd3, 1'b0, LINE3_DEAD, 1'b1, acc);
    idle();
    wait_drain();

    // Invalidate during an in-flight fill: response still comes, tag not kept
    do_req(10'd7, 1'b0, exp_line(7), 1'b0, acc);
    @(posedge clk); #1;
    rreq = 1'b0;
    inv  = 1'b1;
    @(posedge clk); #1 inv = 1'b0;
    wait_drain();
    do_req(10'd7, 1'b0, exp_line(7), 1'b0, acc);
    idle();
    wait_drain();

    // Reset mid-fill: line 5 cached, then a miss on 6 is aborted
    do_req(10'd5, 1'b0, exp_line(5), 1'b0, acc);
    idle();
    wait_drain();
    do_req(10'd6, 1'b0, exp_line(6), 1'b0, acc);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    vq.delete();
    rq.delete();
    #1;
    check("midrst_ren", 256'(ren), 256'(0));
    check("midrst_rrdy", 256'(rrdy), 256'(1));
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_vld", 256'(vld), 256'(0));
    do_req(10'd6, 1'b0, exp_line(6), 1'b0, acc);
    idle();
    wait_drain();
    do_req(10'd5, 1'b0, exp_line(5), 1'b0, acc);
    idle();
    wait_drain();

    check("final_rq_empty", 256'(rq.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
